// File: rtl/inst_prefetch_queue_if.sv
// rtl/inst_prefetch_queue_if.sv - fetch-side and IF-side signal bundle of the prefetch queue
//
// master: the prefetch queue (drives IF head entry and memory request)
// slave : the surrounding pipeline/memory (drives redirect, if_ready, memory response)
//   redirect/redirect_pc : flush and restart fetch at a new PC
//   if_ready/if_valid/if_pc/if_inst : head-entry handshake towards IF
//   mem_req/mem_addr/mem_ack/mem_rdata : single-outstanding fetch port
interface inst_prefetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  redirect, redirect_pc, if_ready, mem_ack, mem_rdata,
        output if_valid, if_pc, if_inst, mem_req, mem_addr
    );

    modport slave (
        output redirect, redirect_pc, if_ready, mem_ack, mem_rdata,
        input  if_valid, if_pc, if_inst, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// rtl/inst_prefetch_queue.sv - instruction prefetch queue between instruction memory and IF
//
// Ports: clk, rst (synchronous, active-high), bus (inst_prefetch_queue_if.master).
// Parameters: DEPTH (power of 2, >=2), RESET_PC (first fetch address).
// Optional feature macro: PREFETCH_BYPASS_EN - when the queue is empty, an ack in WAIT
// is forwarded combinationally to IF in the same cycle.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    inst_prefetch_queue_if.master     bus
);
    localparam int           AW   = $clog2(DEPTH);
    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state;
    logic        mem_req_r;
    logic [31:0] mem_addr_r;
    logic [31:0] saved_pc;
    logic [31:0] q_pc   [DEPTH];
    logic [31:0] q_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    logic [31:0] rpc;
    logic        q_valid;
    logic        ack_in_wait;
    logic        bypass_hit;
    logic        push;
    logic        pop;

    assign rpc         = {bus.redirect_pc[31:2], 2'b00};
    assign q_valid     = (count != '0);
    assign ack_in_wait = (state == WAIT) && bus.mem_ack;

`ifdef PREFETCH_BYPASS_EN
    // Empty queue: the returning word goes straight to IF; it is stored only if IF stalls.
    assign bypass_hit = !q_valid && ack_in_wait && !bus.redirect;
    assign push       = ack_in_wait && !bus.redirect && !(bypass_hit && bus.if_ready);
`else
    assign bypass_hit = 1'b0;
    assign push       = ack_in_wait && !bus.redirect;
`endif

    // A redirect flushes the queue, so a same-cycle handshake must not advance rd_ptr.
    assign pop        = q_valid && bus.if_ready && !bus.redirect;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        bus.if_valid = q_valid || bypass_hit;
        bus.if_pc    = 32'h0;
        bus.if_inst  = 32'h0;
        if (q_valid) begin
            bus.if_pc   = q_pc[rd_ptr];
            bus.if_inst = q_inst[rd_ptr];
        end else if (bypass_hit) begin
            bus.if_pc   = mem_addr_r;
            bus.if_inst = bus.mem_rdata;
        end
    end

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
            saved_pc   <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (bus.redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    q_pc[wr_ptr]   <= mem_addr_r;
                    q_inst[wr_ptr] <= bus.mem_rdata;
                    wr_ptr         <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count_next;
            end

            case (state)
                IDLE: begin
                    if (bus.redirect) begin
                        mem_addr_r <= rpc;
                        state      <= WAIT;
                        mem_req_r  <= 1'b1;
                    end else if (count < FULL) begin
                        state     <= WAIT;
                        mem_req_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.redirect) begin
                        if (bus.mem_ack) begin
                            mem_addr_r <= rpc;
                        end else begin
                            // Request cannot be retracted: keep address, drop its data later.
                            saved_pc <= rpc;
                            state    <= DROP;
                        end
                    end else if (bus.mem_ack) begin
                        mem_addr_r <= mem_addr_r + 32'd4;
                        // Only issue the next request while a slot is guaranteed for it.
                        if (count_next >= FULL) begin
                            state     <= IDLE;
                            mem_req_r <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus.mem_ack) begin
                        mem_addr_r <= bus.redirect ? rpc : saved_pc;
                        state      <= WAIT;
                    end else if (bus.redirect) begin
                        saved_pc <= rpc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb/tb_inst_prefetch_queue.sv - scoreboard testbench for inst_prefetch_queue
module tb_inst_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] exp_q [$];

    inst_prefetch_queue_if bus ();

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; returns at posedge+1 with all pulse inputs cleared.
    task automatic step(input logic ack, input logic [31:0] data, input logic rdy,
                        input logic rd, input logic [31:0] rpc);
        bus.mem_ack     = ack;
        bus.mem_rdata   = data;
        bus.if_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.if_ready  = 1'b0;
        bus.redirect  = 1'b0;
    endtask

    // Monitor: every accepted head entry must match the front of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.if_valid && bus.if_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc=%h inst=%h expected no entry",
                         bus.if_pc, bus.if_inst);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", bus.if_pc, e[63:32]);
                chk("pop_inst", bus.if_inst, e[31:0]);
            end
        end else if (!rst && !bus.if_valid) begin
            chk("idle_pc_zero", bus.if_pc, 32'h0);
            chk("idle_inst_zero", bus.if_inst, 32'h0);
        end
    end

    initial begin
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.if_ready = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("first_req", {31'h0, bus.mem_req}, 32'h1);
        chk("first_addr", bus.mem_addr, 32'h0);

        // Fill to DEPTH with IF stalled, then drain
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({32'(i * 4), 32'hA0 + 32'(i)});
            step(1, 32'hA0 + 32'(i), 0, 0, 0);
        end
        chk("full_req_low", {31'h0, bus.mem_req}, 32'h0);
        chk("full_head_pc", bus.if_pc, 32'h0);
        step(0, 0, 1, 0, 0);
        chk("full_still_idle", {31'h0, bus.mem_req}, 32'h0);
        step(0, 0, 1, 0, 0);
        chk("resume_req", {31'h0, bus.mem_req}, 32'h1);
        chk("resume_addr", bus.mem_addr, 32'h10);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Sustained one instruction per cycle
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({32'h10 + 32'(i * 4), 32'hB0 + 32'(i)});
            step(1, 32'hB0 + 32'(i), 1, 0, 0);
        end
        step(0, 0, 1, 0, 0);
        chk("stream_addr", bus.mem_addr, 32'h1C);
        chk("stream_empty", {31'h0, bus.if_valid}, 32'h0);

        // Redirect without ack: in-flight data dropped, then fetch at new PC
        step(0, 0, 0, 1, 32'h8);
        chk("drop_addr_held", bus.mem_addr, 32'h1C);
        step(1, 32'hBAD0, 0, 0, 0);
        chk("drop_to_wait_addr", bus.mem_addr, 32'h8);
        step(0, 0, 0, 1, 32'h100);
        chk("drop2_req_held", {31'h0, bus.mem_req}, 32'h1);
        chk("drop2_addr_held", bus.mem_addr, 32'h8);
        step(0, 0, 0, 0, 0);
        step(1, 32'hDEAD, 0, 0, 0);
        chk("redir_addr", bus.mem_addr, 32'h100);
        chk("dead_not_visible", {31'h0, bus.if_valid}, 32'h0);
        exp_q.push_back({32'h100, 32'h1111});
        step(1, 32'h1111, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Redirect flushes a held entry; redirect coinciding with ack drops the ack
        step(1, 32'h5555, 0, 0, 0);
        chk("held_entry", {31'h0, bus.if_valid}, 32'h1);
        step(1, 32'h7777, 1, 1, 32'hC);
        chk("flush_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("flush_addr", bus.mem_addr, 32'hC);
        step(1, 32'hCCCC, 0, 1, 32'h200);
        chk("ackredir_valid", {31'h0, bus.if_valid}, 32'h0);
        chk("ackredir_addr", bus.mem_addr, 32'h200);
        chk("ackredir_req", {31'h0, bus.mem_req}, 32'h1);
        exp_q.push_back({32'h200, 32'h2000});
        step(1, 32'h2000, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // PC wraparound and redirect_pc low bits forced to zero
        step(1, 32'hBAD1, 0, 1, 32'hFFFF_FFFF);
        chk("wrap_start_addr", bus.mem_addr, 32'hFFFF_FFFC);
        exp_q.push_back({32'hFFFF_FFFC, 32'hE0});
        exp_q.push_back({32'h0, 32'hE1});
        step(1, 32'hE0, 1, 0, 0);
        chk("wrap_addr", bus.mem_addr, 32'h0);
        step(1, 32'hE1, 1, 0, 0);
        chk("wrap_next_addr", bus.mem_addr, 32'h4);
        step(0, 0, 1, 0, 0);

        // Empty-queue latency (bypass vs registered)
        exp_q.push_back({32'h4, 32'hF00D});
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hF00D; bus.if_ready = 1'b1;
        @(negedge clk);
`ifdef PREFETCH_BYPASS_EN
        chk("ack_cycle_valid", {31'h0, bus.if_valid}, 32'h1);
`else
        chk("ack_cycle_valid", {31'h0, bus.if_valid}, 32'h0);
`endif
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
`ifdef PREFETCH_BYPASS_EN
        chk("after_ack_valid", {31'h0, bus.if_valid}, 32'h0);
`else
        chk("after_ack_valid", {31'h0, bus.if_valid}, 32'h1);
`endif
        step(0, 0, 1, 0, 0);

        // Reset in the middle of a fetch
        chk("pre_rst_req", {31'h0, bus.mem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("midrst_addr", bus.mem_addr, 32'h0);
        chk("midrst_valid", {31'h0, bus.if_valid}, 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
        chk("post_rst_req", {31'h0, bus.mem_req}, 32'h1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
